dnn_infer_ctrl: RTL and testbench

//  Sequencer for one dnn_sigmoid_fix8 inference engine. Accepts a classify request, clears and starts the engine,

---
 rtl/dnn_infer_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_dnn_infer_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_infer_ctrl.sv
// ---------------------------------------------------------------------------------------------
// dnn_infer_ctrl
//   Sequencer for a single dnn_sigmoid_fix8 inference engine. Takes a classify request, clears
//   and starts the engine, and waits for done. The wait can time out. It then walks the engine
//   outputs through the out_idx mux, keeps a running signed argmax, and returns the winning
//   digit and score on a valid/ready result port.
//
// Ports
//   i_clk            clock, all logic on rising edge
//   i_rst            synchronous active-low reset
//   i_req_valid      classify request            o_req_ready    high only while idle
//   i_abort          cancel in-flight inference
//   o_eng_reset      engine reset pulse          o_eng_start    engine start pulse
//   i_eng_done       engine done (level)
//   o_eng_out_idx    engine output select        i_eng_out      signed score for that select
//   o_res_valid      result available            i_res_ready    consumer accepts result
//   o_res_digit      argmax index (all-ones on timeout)
//   o_res_score      winning score (most negative on timeout)
//   o_res_timeout    result produced by timeout
//   o_busy           controller not idle
//   o_stat_count     non-timeout results transferred, wrapping
// ---------------------------------------------------------------------------------------------
module dnn_infer_ctrl #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned IDX_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_abort,
    output logic                  o_eng_reset,
    output logic                  o_eng_start,
    input  logic                  i_eng_done,
    output logic [IDX_WIDTH-1:0]  o_eng_out_idx,
    input  logic [DATA_WIDTH-1:0] i_eng_out,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [IDX_WIDTH-1:0]  o_res_digit,
    output logic [DATA_WIDTH-1:0] o_res_score,
    output logic                  o_res_timeout,
    output logic                  o_busy,
    output logic [15:0]           o_stat_count
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStart,
        StWait,
        StScan,
        StResult,
        StAbort
    } state_e;

    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam bit                    TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0]           TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                        r_state, w_state_d;
    logic [IDX_WIDTH-1:0]          r_idx, w_idx_d;
    logic [15:0]                   r_cnt, w_cnt_d;
    logic signed [DATA_WIDTH-1:0]  r_max, w_max_d;
    logic [IDX_WIDTH-1:0]          r_arg, w_arg_d;

    logic                          r_req_ready;
    logic                          r_eng_reset;
    logic                          r_eng_start;
    logic                          r_res_valid;
    logic [IDX_WIDTH-1:0]          r_res_digit, w_digit_d;
    logic [DATA_WIDTH-1:0]         r_res_score, w_score_d;
    logic                          r_res_timeout, w_tmo_d;
    logic                          r_busy;
    logic [15:0]                   r_stat, w_stat_d;

    logic signed [DATA_WIDTH-1:0]  w_score;
    logic                          w_take;
    logic signed [DATA_WIDTH-1:0]  w_best_score;
    logic [IDX_WIDTH-1:0]          w_best_idx;

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_cnt_d   = r_cnt;
        w_max_d   = r_max;
        w_arg_d   = r_arg;
        w_digit_d = r_res_digit;
        w_score_d = r_res_score;
        w_tmo_d   = r_res_timeout;
        w_stat_d  = r_stat;

        // Running argmax: index 0 seeds the max; only a strictly greater score replaces it,
        // so ties resolve to the lowest index.
        w_score      = $signed(i_eng_out);
        w_take       = (r_idx == '0) || (w_score > r_max);
        w_best_score = w_take ? w_score : r_max;
        w_best_idx   = w_take ? r_idx : r_arg;

        unique case (r_state)
            StIdle: begin
                if (i_req_valid) w_state_d = StClear;
            end
            StClear: begin
                w_state_d = i_abort ? StAbort : StStart;
            end
            StStart: begin
                w_state_d = i_abort ? StAbort : StWait;
                w_cnt_d   = '0;
            end
            StWait: begin
                if (i_abort) begin
                    w_state_d = StAbort;
                end else if (i_eng_done) begin
                    // Done beats a timeout landing in the same cycle.
                    w_state_d = StScan;
                    w_idx_d   = '0;
                end else if (TO_EN && (r_cnt == TO_LAST)) begin
                    w_state_d = StResult;
                    w_digit_d = '1;
                    w_score_d = MOST_NEG;
                    w_tmo_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 16'd1;
                end
            end
            StScan: begin
                if (i_abort) begin
                    w_state_d = StAbort;
                    w_idx_d   = '0;
                end else begin
                    w_max_d = w_best_score;
                    w_arg_d = w_best_idx;
                    if (r_idx == LAST_IDX) begin
                        w_state_d = StResult;
                        w_idx_d   = '0;
                        w_digit_d = w_best_idx;
                        w_score_d = w_best_score;
                        w_tmo_d   = 1'b0;
                    end else begin
                        w_idx_d = r_idx + IDX_WIDTH'(1);
                    end
                end
            end
            StResult: begin
                if (i_res_ready) begin
                    w_state_d = StIdle;
                    if (!r_res_timeout) w_stat_d = r_stat + 16'd1;
                end
            end
            StAbort: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_idx_d   = '0;
            end
        endcase
    end

    // Pulse/level outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_max         <= '0;
            r_arg         <= '0;
            r_req_ready   <= 1'b1;
            r_eng_reset   <= 1'b0;
            r_eng_start   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_digit   <= '0;
            r_res_score   <= '0;
            r_res_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_stat        <= '0;
        end else begin
            r_state       <= w_state_d;
            r_idx         <= w_idx_d;
            r_cnt         <= w_cnt_d;
            r_max         <= w_max_d;
            r_arg         <= w_arg_d;
            r_req_ready   <= (w_state_d == StIdle);
            r_eng_reset   <= (w_state_d == StClear) || (w_state_d == StAbort);
            r_eng_start   <= (w_state_d == StStart);
            r_res_valid   <= (w_state_d == StResult);
            r_res_digit   <= w_digit_d;
            r_res_score   <= w_score_d;
            r_res_timeout <= w_tmo_d;
            r_busy        <= (w_state_d != StIdle);
            r_stat        <= w_stat_d;
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_eng_reset   = r_eng_reset;
    assign o_eng_start   = r_eng_start;
    assign o_eng_out_idx = r_idx;
    assign o_res_valid   = r_res_valid;
    assign o_res_digit   = r_res_digit;
    assign o_res_score   = r_res_score;
    assign o_res_timeout = r_res_timeout;
    assign o_busy        = r_busy;
    assign o_stat_count  = r_stat;

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_dnn_infer_ctrl
//   Two controllers: A (timeout disabled) driven by a small engine model that raises done 20
//   cycles after start, and B (TIMEOUT_CYCLES=8) whose done is driven directly. Expected results
//   are queued when a request is issued; a monitor pops them when res_valid rises and keeps
//   comparing until the transfer.
// ---------------------------------------------------------------------------------------------
module tb_dnn_infer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] digit;
        logic [7:0] score;
        logic       tmo;
        int         cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    logic signed [7:0] tbl [16];

    int t1 [10] = '{-5, 3, 7, 7, -128, 0, 1, 2, 6, -1};
    int t2 [10] = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    int t3 [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    int t4 [10] = '{-100, 50, -2, 49, 0, 0, 0, 0, 0, 0};

    // DUT A
    logic       a_req_valid = 1'b0, a_abort = 1'b0, a_res_ready = 1'b1;
    logic       a_req_ready, a_eng_reset, a_eng_start, a_eng_done;
    logic [3:0] a_idx, a_digit;
    logic [7:0] a_out, a_score;
    logic       a_res_valid, a_tmo, a_busy;
    logic [15:0] a_stat;

    // DUT B
    logic       b_req_valid = 1'b0, b_abort = 1'b0, b_res_ready = 1'b1, b_done = 1'b0;
    logic       b_req_ready, b_eng_reset, b_eng_start;
    logic [3:0] b_idx, b_digit;
    logic [7:0] b_out, b_score;
    logic       b_res_valid, b_tmo, b_busy;
    logic [15:0] b_stat;

    dnn_infer_ctrl #(
        .DATA_WIDTH(8), .NUM_CLASSES(10), .IDX_WIDTH(4), .TIMEOUT_CYCLES(0)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_abort(a_abort), .o_eng_reset(a_eng_reset), .o_eng_start(a_eng_start),
        .i_eng_done(a_eng_done), .o_eng_out_idx(a_idx), .i_eng_out(a_out),
        .o_res_valid(a_res_valid), .i_res_ready(a_res_ready), .o_res_digit(a_digit),
        .o_res_score(a_score), .o_res_timeout(a_tmo), .o_busy(a_busy), .o_stat_count(a_stat)
    );

    dnn_infer_ctrl #(
        .DATA_WIDTH(8), .NUM_CLASSES(10), .IDX_WIDTH(4), .TIMEOUT_CYCLES(8)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_abort(b_abort), .o_eng_reset(b_eng_reset), .o_eng_start(b_eng_start),
        .i_eng_done(b_done), .o_eng_out_idx(b_idx), .i_eng_out(b_out),
        .o_res_valid(b_res_valid), .i_res_ready(b_res_ready), .o_res_digit(b_digit),
        .o_res_score(b_score), .o_res_timeout(b_tmo), .o_busy(b_busy), .o_stat_count(b_stat)
    );

    // Engine model for A: done rises 20 cycles after the start cycle, cleared by eng_reset.
    logic m_done = 1'b0;
    logic stuck  = 1'b0;
    int   m_cnt  = 0;
    always @(posedge clk) begin
        if (a_eng_reset) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
        end else if (a_eng_start) begin
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == 19) begin
                m_done <= 1'b1;
                m_cnt  <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    assign a_eng_done = m_done | stuck;
    assign a_out      = tbl[a_idx];
    assign b_out      = tbl[b_idx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input bit to_b, input logic [3:0] d, input logic [7:0] s,
                        input logic t, input int c);
        exp_t e;
        e.digit = d;
        e.score = s;
        e.tmo   = t;
        e.cyc   = c;
        if (to_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic load(input int v [10]);
        for (int i = 0; i < 16; i++) tbl[i] = 8'sd0;
        for (int i = 0; i < 10; i++) tbl[i] = 8'(v[i]);
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next();
    endtask

    task automatic req_a(output int c0);
        a_req_valid = 1'b1;
        chk("A_req_ready_idle", a_req_ready, 1);
        c0 = cyc;
        next();
        a_req_valid = 1'b0;
    endtask

    task automatic req_b(output int c0);
        b_req_valid = 1'b1;
        chk("B_req_ready_idle", b_req_ready, 1);
        c0 = cyc;
        next();
        b_req_valid = 1'b0;
    endtask

    // Scoreboard monitor for both controllers.
    bit   a_have = 0, a_bad = 0, b_have = 0, b_bad = 0;
    exp_t a_cur, b_cur;
    initial forever begin
        @(negedge clk);
        if (rst && a_res_valid) begin
            if (!a_have) begin
                a_have = 1;
                if (qa.size() == 0) begin
                    a_bad = 1;
                    n_tests++;
                    n_fail++;
                    $display("FAIL A_unexpected_result: got digit %0d, expected no result", a_digit);
                end else begin
                    a_cur = qa.pop_front();
                    chk("A_res_valid_cycle", cyc, a_cur.cyc);
                end
            end
            if (!a_bad) begin
                chk("A_res_digit", a_digit, a_cur.digit);
                chk("A_res_score", a_score, a_cur.score);
                chk("A_res_timeout", a_tmo, a_cur.tmo);
                chk("A_req_ready_in_result", a_req_ready, 0);
            end
            if (a_res_ready) begin
                a_have = 0;
                a_bad  = 0;
            end
        end
        if (rst && b_res_valid) begin
            if (!b_have) begin
                b_have = 1;
                if (qb.size() == 0) begin
                    b_bad = 1;
                    n_tests++;
                    n_fail++;
                    $display("FAIL B_unexpected_result: got digit %0d, expected no result", b_digit);
                end else begin
                    b_cur = qb.pop_front();
                    chk("B_res_valid_cycle", cyc, b_cur.cyc);
                end
            end
            if (!b_bad) begin
                chk("B_res_digit", b_digit, b_cur.digit);
                chk("B_res_score", b_score, b_cur.score);
                chk("B_res_timeout", b_tmo, b_cur.tmo);
                chk("B_busy_in_result", b_busy, 1);
            end
            if (b_res_ready) begin
                b_have = 0;
                b_bad  = 0;
            end
        end
    end

    initial begin
        int c0;

        // Reset
        load(t1);
        next(); next(); next();
        rst = 1'b1;
        chk("RST_req_ready", a_req_ready, 1);
        chk("RST_eng_reset", a_eng_reset, 0);
        chk("RST_eng_start", a_eng_start, 0);
        chk("RST_out_idx", a_idx, 0);
        chk("RST_res_valid", a_res_valid, 0);
        chk("RST_res_digit", a_digit, 0);
        chk("RST_res_score", a_score, 0);
        chk("RST_res_timeout", a_tmo, 0);
        chk("RST_busy", a_busy, 0);
        chk("RST_stat", a_stat, 0);
        next();
        chk("RST_req_ready_after", a_req_ready, 1);

        // Normal run with backpressure; abort while in RESULT must be ignored.
        req_a(c0);
        push(0, 4'd2, 8'd7, 1'b0, c0 + 33);
        chk("T1_clear_reset", a_eng_reset, 1);
        chk("T1_clear_start", a_eng_start, 0);
        chk("T1_clear_ready", a_req_ready, 0);
        next();
        chk("T1_start_start", a_eng_start, 1);
        chk("T1_start_reset", a_eng_reset, 0);
        next();
        chk("T1_wait_start", a_eng_start, 0);
        chk("T1_wait_busy", a_busy, 1);
        a_res_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            goto(c0 + 23 + k);
            chk("T1_scan_idx", a_idx, k);
        end
        goto(c0 + 34);
        a_abort = 1'b1;
        next();
        a_abort = 1'b0;
        chk("T1_abort_in_result_reset", a_eng_reset, 0);
        chk("T1_abort_in_result_valid", a_res_valid, 1);
        goto(c0 + 38);
        chk("T1_stat_before", a_stat, 0);
        a_res_ready = 1'b1;
        next();
        chk("T1_req_ready_after", a_req_ready, 1);
        chk("T1_stat_after", a_stat, 1);
        chk("T1_valid_dropped", a_res_valid, 0);

        // Abort during SCAN at k=4, then a normal run with signed scores.
        req_a(c0);
        goto(c0 + 27);
        chk("T4_scan_k4", a_idx, 4);
        a_abort = 1'b1;
        next();
        a_abort = 1'b0;
        chk("T4_abort_reset", a_eng_reset, 1);
        chk("T4_abort_idx", a_idx, 0);
        chk("T4_abort_valid", a_res_valid, 0);
        chk("T4_abort_ready", a_req_ready, 0);
        next();
        chk("T4_idle_reset", a_eng_reset, 0);
        chk("T4_idle_ready", a_req_ready, 1);
        chk("T4_idle_busy", a_busy, 0);
        goto(c0 + 40);
        chk("T4_no_result", a_res_valid, 0);
        load(t4);
        req_a(c0);
        push(0, 4'd1, 8'd50, 1'b0, c0 + 33);
        goto(c0 + 34);
        chk("T4_stat_after", a_stat, 2);
        chk("T4_ready_after", a_req_ready, 1);

        // Stale done held high: must not scan before CLEAR and START; ties keep index 0.
        load(t2);
        stuck = 1'b1;
        req_a(c0);
        push(0, 4'd0, 8'h80, 1'b0, c0 + 14);
        chk("T5_clear_reset", a_eng_reset, 1);
        chk("T5_clear_idx", a_idx, 0);
        next();
        chk("T5_start_start", a_eng_start, 1);
        chk("T5_start_idx", a_idx, 0);
        goto(c0 + 5);
        chk("T5_scan_k1", a_idx, 1);
        goto(c0 + 15);
        stuck = 1'b0;
        chk("T5_stat_after", a_stat, 3);

        // Reset during WAIT: everything back to reset values, no result.
        req_a(c0);
        goto(c0 + 5);
        chk("T6_busy_wait", a_busy, 1);
        rst = 1'b0;
        next();
        rst = 1'b1;
        chk("T6_req_ready", a_req_ready, 1);
        chk("T6_busy", a_busy, 0);
        chk("T6_eng_reset", a_eng_reset, 0);
        chk("T6_eng_start", a_eng_start, 0);
        chk("T6_stat", a_stat, 0);
        chk("T6_res_valid", a_res_valid, 0);
        next();
        chk("T6_req_ready_next", a_req_ready, 1);
        goto(c0 + 40);
        chk("T6_no_result", a_res_valid, 0);

        // Timeout on B: 8 WAIT cycles without done.
        req_b(c0);
        push(1, 4'd15, 8'h80, 1'b1, c0 + 11);
        chk("B_clear_reset", b_eng_reset, 1);
        next();
        chk("B_start_start", b_eng_start, 1);
        goto(c0 + 10);
        chk("B_wait_last_busy", b_busy, 1);
        chk("B_wait_last_valid", b_res_valid, 0);
        goto(c0 + 12);
        chk("B_stat_after_timeout", b_stat, 0);
        chk("B_ready_after_timeout", b_req_ready, 1);

        // Done on the last WAIT cycle beats the timeout; winner at the last index.
        load(t3);
        req_b(c0);
        push(1, 4'd9, 8'd127, 1'b0, c0 + 21);
        goto(c0 + 10);
        b_done = 1'b1;
        next();
        b_done = 1'b0;
        chk("B_done_wins_scan", b_idx, 0);
        goto(c0 + 22);
        chk("B_stat_after_done", b_stat, 1);

        next(); next();
        chk("A_results_outstanding", qa.size(), 0);
        chk("B_results_outstanding", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
